// File: rtl/apb_req_arbiter_if.sv
// Requester-side and IP-side signal bundle for apb_req_arbiter.
// master: the arbiter's view; slave: the surrounding requesters and IP.
interface apb_req_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         req_rdata;
    logic                          req_err;
    logic [NUM_REQ-1:0]            grant;
    logic                          ip_valid;
    logic                          ip_write;
    logic [ADDR_WIDTH-1:0]         ip_addr;
    logic [DATA_WIDTH-1:0]         ip_wdata;
    logic                          ip_ready;
    logic [DATA_WIDTH-1:0]         ip_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, ip_ready, ip_rdata,
        output req_ready, req_rdata, req_err, grant,
               ip_valid, ip_write, ip_addr, ip_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, ip_ready, ip_rdata,
        input  req_ready, req_rdata, req_err, grant,
               ip_valid, ip_write, ip_addr, ip_wdata
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one IP register port between NUM_REQ requesters.
// Optional IP response timeout enabled by defining ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | sample requesters, grant next in round-robin order, capture command
// ISSUE | command presented to IP, waiting for ip_ready (or timeout)
// RESP  | one-cycle completion pulse to the owner, pointer update
module apb_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TO_CYCLES  = 255
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    apb_req_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   owner;
    logic            pick_any;
    logic [IW-1:0]   pick_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = (TO_CYCLES < 256) ? 8 : $clog2(TO_CYCLES + 1);
    logic [TW-1:0]   to_cnt;
    logic            err_q;
    assign bus.req_err = err_q;
`else
    assign bus.req_err = 1'b0;
`endif

    // First valid requester strictly after the last owner, wrapping around.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!pick_any && bus.req_valid[(int'(last) + i) % NUM_REQ]) begin
                pick_any = 1'b1;
                pick_idx = IW'((int'(last) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            last          <= IW'(NUM_REQ - 1);
            owner         <= '0;
            bus.grant     <= '0;
            bus.ip_valid  <= 1'b0;
            bus.ip_write  <= 1'b0;
            bus.ip_addr   <= '0;
            bus.ip_wdata  <= '0;
            bus.req_ready <= '0;
            bus.req_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
            to_cnt        <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner        <= pick_idx;
                        bus.grant    <= NUM_REQ'(1) << pick_idx;
                        bus.ip_write <= bus.req_write[pick_idx];
                        bus.ip_addr  <= bus.req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        bus.ip_wdata <= bus.req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        bus.ip_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        to_cnt       <= TW'(TO_CYCLES - 1);
`endif
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.ip_ready) begin
                        bus.ip_valid  <= 1'b0;
                        bus.req_ready <= bus.grant;
                        bus.req_rdata <= bus.ip_write ? '0 : bus.ip_rdata;
                        state         <= RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (to_cnt == '0) begin
                        bus.ip_valid  <= 1'b0;
                        bus.req_ready <= bus.grant;
                        bus.req_rdata <= '0;
                        err_q         <= 1'b1;
                        state         <= RESP;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
`endif
                end
                RESP: begin
                    bus.req_ready <= '0;
                    bus.req_rdata <= '0;
                    bus.grant     <= '0;
                    last          <= owner;
`ifdef ARB_TIMEOUT_EN
                    err_q         <= 1'b0;
`endif
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: fixed vectors, hand sequences and randomized
// transactions against a distance-based round-robin model.
module tb_apb_req_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_req_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    apb_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TO_CYCLES(TO)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int model_last;
    logic [AW-1:0] addr [N];
    logic [DW-1:0] wdat [N];

    typedef struct {
        logic [3:0] valid;
        logic [3:0] write;
        int         delay;
        int         exp_idx;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Winner is the valid requester at the smallest forward distance from the last owner.
    function automatic int model_pick(input logic [3:0] v);
        int best = -1;
        int bd   = N + 1;
        for (int k = 0; k < N; k++) begin
            if (v[k] && ((k - model_last - 1 + N) % N) < bd) begin
                bd   = (k - model_last - 1 + N) % N;
                best = k;
            end
        end
        return best;
    endfunction

    task automatic randomize_cmds();
        for (int k = 0; k < N; k++) begin
            addr[k] = $urandom;
            wdat[k] = $urandom;
        end
    endtask

    task automatic drive_reqs(input logic [3:0] v, input logic [3:0] w);
        for (int k = 0; k < N; k++) begin
            bus.req_addr[k*AW +: AW]  = addr[k];
            bus.req_wdata[k*DW +: DW] = wdat[k];
        end
        bus.req_write = w;
        bus.req_valid = v;
    endtask

    task automatic do_txn(input logic [3:0] v, input logic [3:0] w, input int delay,
                          input int exp_idx, input logic [DW-1:0] rd, input bit drop,
                          input string nm, output int lat);
        logic [3:0] oh;
        int n;
        drive_reqs(v, w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ip_valid && n < 8);
        lat = n;
        chk({nm, " ip_valid"}, 64'(bus.ip_valid), 64'd1);
        if (!bus.ip_valid) return;
        if (drop) bus.req_valid = '0;
        oh = 4'b0001 << exp_idx;
        chk({nm, " grant"}, 64'(bus.grant), 64'(oh));
        chk({nm, " ip_addr"}, 64'(bus.ip_addr), 64'(addr[exp_idx]));
        chk({nm, " ip_write"}, 64'(bus.ip_write), 64'(w[exp_idx]));
        if (w[exp_idx]) chk({nm, " ip_wdata"}, 64'(bus.ip_wdata), 64'(wdat[exp_idx]));
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            chk({nm, " ip_valid held"}, 64'(bus.ip_valid), 64'd1);
        end
        bus.ip_ready = 1'b1;
        bus.ip_rdata = rd;
        @(negedge clk);
        bus.ip_ready = 1'b0;
        chk({nm, " req_ready"}, 64'(bus.req_ready), 64'(oh));
        chk({nm, " req_rdata"}, 64'(bus.req_rdata), w[exp_idx] ? 64'd0 : 64'(rd));
        chk({nm, " req_err"}, 64'(bus.req_err), 64'd0);
        chk({nm, " ip_valid low"}, 64'(bus.ip_valid), 64'd0);
        model_last = exp_idx;
    endtask

    task automatic go_idle();
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_dut();
        bus.req_valid = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_last = N - 1;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " grant"}, 64'(bus.grant), 64'd0);
        chk({nm, " ip_valid"}, 64'(bus.ip_valid), 64'd0);
        chk({nm, " ip_addr"}, 64'(bus.ip_addr), 64'd0);
        chk({nm, " req_ready"}, 64'(bus.req_ready), 64'd0);
        chk({nm, " req_rdata"}, 64'(bus.req_rdata), 64'd0);
        chk({nm, " req_err"}, 64'(bus.req_err), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int e;
        logic [3:0] v;
        logic [3:0] w;

        vecs[0] = '{4'b0001, 4'b0000, 0, 0};
        vecs[1] = '{4'b1111, 4'b0101, 1, 1};
        vecs[2] = '{4'b1111, 4'b0101, 0, 2};
        vecs[3] = '{4'b1001, 4'b0000, 2, 3};
        vecs[4] = '{4'b1001, 4'b1001, 0, 0};
        vecs[5] = '{4'b0100, 4'b0100, 3, 2};
        vecs[6] = '{4'b0011, 4'b0000, 1, 0};
        vecs[7] = '{4'b1110, 4'b0010, 0, 1};

        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.ip_ready  = 1'b0;
        bus.ip_rdata  = '0;
        model_last    = N - 1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        randomize_cmds();
        addr[1] = 32'h10;
        do_txn(4'b0010, 4'b0000, 2, 1, 32'hA5A5_0001, 1'b0, "single_rd", lat);
        chk("single_rd ip_latency", 64'(lat), 64'd1);
        bus.req_valid = '0;
        @(negedge clk);
        chk("single_rd pulse_width", 64'(bus.req_ready), 64'd0);
        chk("single_rd grant_clear", 64'(bus.grant), 64'd0);
        go_idle();

        addr[2] = 32'h20;
        wdat[2] = 32'hDEAD_BEEF;
        do_txn(4'b0100, 4'b0100, 0, 2, 32'h1234_5678, 1'b0, "single_wr", lat);
        chk("single_wr ip_latency", 64'(lat), 64'd1);
        go_idle();

        reset_dut();
        for (int i = 0; i < 8; i++) begin
            randomize_cmds();
            do_txn(vecs[i].valid, vecs[i].write, vecs[i].delay, vecs[i].exp_idx,
                   $urandom, 1'b0, $sformatf("vec%0d", i), lat);
        end
        go_idle();

        reset_dut();
        for (int i = 0; i < 8; i++) begin
            randomize_cmds();
            do_txn(4'b1111, 4'(i), 0, i % N, $urandom, 1'b0, $sformatf("fair%0d", i), lat);
        end
        go_idle();

        for (int i = 0; i < 60; i++) begin
            randomize_cmds();
            v = 4'($urandom_range(1, 15));
            w = 4'($urandom_range(0, 15));
            e = model_pick(v);
            do_txn(v, w, $urandom_range(0, 3), e, $urandom, ($urandom_range(0, 3) == 0),
                   $sformatf("rnd%0d", i), lat);
        end
        go_idle();

        randomize_cmds();
        drive_reqs(4'b0010, 4'b0000);
        @(negedge clk);
        chk("rst_mid ip_valid", 64'(bus.ip_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid async");
        bus.req_valid = '0;
        @(negedge clk);
        chk_all_zero("rst_mid held");
        rst_n = 1'b1;
        model_last = N - 1;
        @(negedge clk);
        randomize_cmds();
        do_txn(4'b1111, 4'b0000, 0, 0, $urandom, 1'b0, "rst_mid after", lat);
        go_idle();

`ifdef ARB_TIMEOUT_EN
        randomize_cmds();
        bus.ip_rdata = 32'hFFFF_FFFF;
        drive_reqs(4'b0001, 4'b0000);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.ip_valid && lat < 8);
        chk("timeout ip_valid", 64'(bus.ip_valid), 64'd1);
        lat = 0;
        while (bus.ip_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("timeout cycles", 64'(lat), 64'(TO));
        chk("timeout req_ready", 64'(bus.req_ready), 64'd1);
        chk("timeout req_err", 64'(bus.req_err), 64'd1);
        chk("timeout req_rdata", 64'(bus.req_rdata), 64'd0);
        bus.req_valid = '0;
        bus.ip_ready  = 1'b1;
        @(negedge clk);
        bus.ip_ready  = 1'b0;
        chk("timeout late_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("timeout late_ready2", 64'(bus.req_ready), 64'd0);
        chk("timeout err_clear", 64'(bus.req_err), 64'd0);
        go_idle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
